// File: rtl/vec_pkg.sv
// Shared encodings and helpers for the vector compute units (32-bit lane / two 16-bit lanes).
package vec_pkg;

  localparam int         LANE_W   = 16;
  localparam logic       WIDTH_32 = 1'b0;
  localparam logic       WIDTH_16 = 1'b1;
  localparam logic [5:0] ITER_32  = 6'd32;
  localparam logic [5:0] ITER_16  = 6'd16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Per-lane two's-complement negate; in 32-bit mode only en[0] is consulted.
  function automatic logic [31:0] lane_neg(input logic [31:0] x, input logic w, input logic [1:0] en);
    logic [31:0] r;
    if (w == WIDTH_32) begin
      r = en[0] ? (32'd0 - x) : x;
    end else begin
      r[15:0]  = en[0] ? (16'd0 - x[15:0])  : x[15:0];
      r[31:16] = en[1] ? (16'd0 - x[31:16]) : x[31:16];
    end
    return r;
  endfunction

endpackage

// File: rtl/vec_sub33.sv
// 33-bit partitioned subtractor: a - b as one 33-bit lane, or lanes [15:0] and [32:16] with the
// borrow blocked at bit 16 by a guard bit. borrow[0] is out of the low half, borrow[1] out of bit 32.
module vec_sub33
  import vec_pkg::*;
(
  input  logic        width,
  input  logic [32:0] a,
  input  logic [32:0] b,
  output logic [32:0] diff,
  output logic [1:0]  borrow
);

  logic [34:0] sum;

  // Guard column: a=1, b'=width. In 32-bit mode it forwards the low carry; in 16-bit mode it
  // swallows it and injects the +1 the upper lane needs for its own subtraction.
  assign sum = {1'b0, a[32:16], 1'b1, a[15:0]} + {1'b0, ~b[32:16], width, ~b[15:0]} + 35'd1;

  assign diff      = {sum[33:17], sum[15:0]};
  assign borrow[1] = ~sum[34];
  assign borrow[0] = (width == WIDTH_16) ? ~sum[16] : sum[16];

endmodule

// File: rtl/vec_div32.sv
// Iterative restoring radix-2 divider, one 32-bit lane or two 16-bit lanes, valid/ready on both sides.
// Optional signed mode under `SIGNED_DIV_EN (adds sgn port and a FIX cycle).
module vec_div32
  import vec_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              width,
`ifdef SIGNED_DIV_EN
  input  logic              sgn,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic [1:0]        div_zero
);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              mode;
  logic [DATA_W-1:0] rem, quo, dvs;
  logic [1:0]        dz, dz_in, ok, borrow;
  logic [32:0]       sub_a, sub_b, diff;
  logic [DATA_W-1:0] rem_nxt, quo_nxt;
  logic              last;
  logic              diff_unused;

  assign in_ready    = (state == ST_IDLE);
  assign out_valid   = (state == ST_DONE);
  assign last        = (cnt == CNT_W'(1));
  assign sub_b       = {1'b0, dvs};
  assign diff_unused = diff[32];
  assign dz_in       = (width == WIDTH_32) ? {2{divisor == 32'd0}}
                                           : {divisor[31:16] == 16'd0, divisor[15:0] == 16'd0};

  // Lane0's shifted remainder is 17 bits; its top bit rides outside the subtractor because a set
  // top bit guarantees the trial subtraction succeeds and the result fits in 16 bits.
  always_comb begin
    sub_a   = (mode == WIDTH_32) ? {rem, quo[31]} : {rem[31:16], quo[31], rem[14:0], quo[15]};
    ok[1]   = ~borrow[1];
    ok[0]   = (mode == WIDTH_32) ? ~borrow[1] : (rem[15] | ~borrow[0]);
    rem_nxt = {ok[1] ? diff[31:16] : sub_a[31:16], ok[0] ? diff[15:0] : sub_a[15:0]};
    quo_nxt = (mode == WIDTH_32) ? {quo[30:0], ok[1]} : {quo[30:16], ok[1], quo[14:0], ok[0]};
  end

  vec_sub33 u_sub (
    .width  (mode),
    .a      (sub_a),
    .b      (sub_b),
    .diff   (diff),
    .borrow (borrow)
  );

`ifdef SIGNED_DIV_EN
  logic              sgn_r;
  logic [1:0]        neg_q, neg_r, sd, sv;
  logic [DATA_W-1:0] raw_dvd, q_fix, r_fix;

  assign sd    = ((width == WIDTH_32) ? {2{dividend[31]}} : {dividend[31], dividend[15]}) & {2{sgn}};
  assign sv    = ((width == WIDTH_32) ? {2{divisor[31]}}  : {divisor[31],  divisor[15]})  & {2{sgn}};
  assign q_fix = lane_neg(quo, mode, neg_q);
  assign r_fix = lane_neg(rem, mode, neg_r);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      mode      <= WIDTH_32;
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
      dz        <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= '0;
`ifdef SIGNED_DIV_EN
      sgn_r     <= 1'b0;
      neg_q     <= '0;
      neg_r     <= '0;
      raw_dvd   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          mode  <= width;
          rem   <= '0;
          dz    <= dz_in;
          cnt   <= (width == WIDTH_16) ? CNT_W'(ITER_16) : CNT_W'(ITER_32);
          state <= ST_RUN;
`ifdef SIGNED_DIV_EN
          quo     <= lane_neg(dividend, width, sd);
          dvs     <= lane_neg(divisor, width, sv);
          sgn_r   <= sgn;
          neg_q   <= sd ^ sv;
          neg_r   <= sd;
          raw_dvd <= dividend;
`else
          quo     <= dividend;
          dvs     <= divisor;
`endif
        end
        ST_RUN: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt - CNT_W'(1);
          if (last) begin
`ifdef SIGNED_DIV_EN
            if (sgn_r) state <= ST_FIX;
            else
`endif
            begin
              state     <= ST_DONE;
              quotient  <= quo_nxt;
              remainder <= rem_nxt;
              div_zero  <= dz;
            end
          end
        end
`ifdef SIGNED_DIV_EN
        // Zero-divisor lanes report the raw dividend, not the magnitude that was divided.
        ST_FIX: begin
          quotient  <= {dz[1] ? 16'hFFFF : q_fix[31:16], dz[0] ? 16'hFFFF : q_fix[15:0]};
          remainder <= {dz[1] ? raw_dvd[31:16] : r_fix[31:16], dz[0] ? raw_dvd[15:0] : r_fix[15:0]};
          div_zero  <= dz;
          state     <= ST_DONE;
        end
`endif
        ST_DONE: if (out_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_div32.sv
// Scoreboard bench for vec_div32: stimulus pushes model results, a negedge monitor pops and compares.
module tb_vec_div32;

  typedef longint unsigned u64_t;
  typedef longint          i64_t;
  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic [1:0]  z;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, width, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] dividend, divisor, quotient, remainder;
  logic [1:0]  div_zero;
`ifdef SIGNED_DIV_EN
  logic        sgn;
`endif

  exp_t exp_q[$];
  int   n_chk = 0, n_fail = 0, cyc = 0;
  bit   rand_ready = 1'b1, force_ready = 1'b1;

  vec_div32 dut (
    .clk       (clk),
    .rst       (rst),
    .width     (width),
`ifdef SIGNED_DIV_EN
    .sgn       (sgn),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", nm, act, req);
    end
  endtask

  // Reference: plain integer division per lane, SV's truncating / and % for signed lanes.
  function automatic void lane_model(input u64_t a, input u64_t b, input int L, input bit s,
                                     output u64_t q, output u64_t r, output bit z);
    u64_t mask;
    i64_t sa, sb;
    mask = (u64_t'(1) << L) - 1;
    z    = (b == 0);
    if (z) begin
      q = mask;
      r = a;
    end else if (s) begin
      sa = ((a >> (L - 1)) != 0) ? i64_t'(a) - (i64_t'(1) << L) : i64_t'(a);
      sb = ((b >> (L - 1)) != 0) ? i64_t'(b) - (i64_t'(1) << L) : i64_t'(b);
      q  = u64_t'(sa / sb) & mask;
      r  = u64_t'(sa % sb) & mask;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic w, input bit s);
    exp_t e;
    u64_t q0, r0, q1, r1;
    bit   z0, z1;
    if (!w) begin
      lane_model(u64_t'(a), u64_t'(b), 32, s, q0, r0, z0);
      e.q = q0[31:0]; e.r = r0[31:0]; e.z = {z0, z0}; e.lat = 33;
    end else begin
      lane_model(u64_t'(a[15:0]),  u64_t'(b[15:0]),  16, s, q0, r0, z0);
      lane_model(u64_t'(a[31:16]), u64_t'(b[31:16]), 16, s, q1, r1, z1);
      e.q = {q1[15:0], q0[15:0]}; e.r = {r1[15:0], r0[15:0]}; e.z = {z1, z0}; e.lat = 17;
    end
    if (s) e.lat++;
    e.acc = 0;
    return e;
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic w, input bit s);
    exp_t e;
    int   g = 0;
    @(negedge clk);
    while (!in_ready && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      n_chk++; n_fail++;
      $display("FAIL send_wait: in_ready=%0b required=1 within 500 cycles", in_ready);
    end else begin
      e     = model(a, b, w, s);
      e.acc = cyc + 1;
      exp_q.push_back(e);
      dividend = a; divisor = b; width = w; in_valid = 1'b1;
`ifdef SIGNED_DIV_EN
      sgn = s;
`endif
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    while (exp_q.size() != 0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 7))
      0:       return 16'd0;
      1, 2:    return 16'($urandom_range(1, 15));
      3:       return 16'($urandom_range(0, 255));
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1, 2:    return 32'($urandom_range(1, 15));
      3:       return 32'($urandom) >> $urandom_range(8, 28);
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin : ready_driver
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : force_ready;
    end
  end

  initial begin : monitor
    exp_t e;
    bit   seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
      end else if (out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_result: out_valid=1 quotient=0x%08h required no result", quotient);
          end else begin
            check("latency", 32'(cyc - exp_q[0].acc + 1), 32'(exp_q[0].lat));
          end
        end
        if (out_ready) begin
          seen = 1'b0;
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("quotient", quotient, e.q);
            check("remainder", remainder, e.r);
            check("div_zero", 32'(div_zero), 32'(e.z));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int      g;
    logic    w;
    bit      s;
    logic [31:0] a, b;
    rst = 1'b1; in_valid = 1'b0; width = 1'b0; dividend = '0; divisor = '0;
`ifdef SIGNED_DIV_EN
    sgn = 1'b0;
`endif
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_div_zero", 32'(div_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    send(32'd100, 32'd7, 1'b0, 1'b0);
    // Offers while busy must be refused and never produce a result of their own.
    dividend = 32'hFFFF; divisor = 32'd1; width = 1'b1; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("busy_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    wait_idle();

    send({16'd50, 16'd9}, {16'd5, 16'd2}, 1'b1, 1'b0);
    send({16'd7, 16'd7}, {16'd0, 16'd3}, 1'b1, 1'b0);
    send(32'd5, 32'd9, 1'b0, 1'b0);
    send(32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    send({16'hFFFF, 16'd1234}, {16'd1, 16'hFFFF}, 1'b1, 1'b0);
    wait_idle();

    rand_ready = 1'b0; force_ready = 1'b0;
    @(posedge clk); @(posedge clk);
    send(32'd1000, 32'd10, 1'b0, 1'b0);
    g = 0;
    while (!out_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    repeat (10) begin
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_quotient", quotient, 32'd100);
      check("hold_remainder", remainder, 32'd0);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    force_ready = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_out_valid", 32'(out_valid), 32'd0);
    rand_ready = 1'b1;

    send(32'd100, 32'd7, 1'b0, 1'b0);
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrun_rst_out_valid", 32'(out_valid), 32'd0);
    check("midrun_rst_in_ready", 32'(in_ready), 32'd1);
    check("midrun_rst_quotient", quotient, 32'd0);
    check("midrun_rst_remainder", remainder, 32'd0);
    exp_q.delete();
    @(negedge clk);
    #1 rst = 1'b0;
    send(32'd100, 32'd7, 1'b0, 1'b0);
    wait_idle();

    for (int i = 0; i < 60; i++) begin
      w = 1'($urandom_range(0, 1));
      s = 1'b0;
`ifdef SIGNED_DIV_EN
      s = 1'($urandom_range(0, 1));
`endif
      if (w) begin
        a = {pick16(), pick16()};
        b = {pick16(), pick16()};
      end else begin
        a = pick32();
        b = pick32();
      end
      send(a, b, w, s);
    end

`ifdef SIGNED_DIV_EN
    send(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
    send(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
    send({16'h8000, 16'hFFF9}, {16'hFFFF, 16'd2}, 1'b1, 1'b1);
    send(32'hFFFF_FFF9, 32'd0, 1'b0, 1'b1);
`endif
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
